// File: rtl/da_bit_sequencer.sv
// Control sequencer for the distributed-arithmetic FIR: loads the tap shift
// registers on a handshake, steps them N cycles LSB-first, then holds the result.
module da_bit_sequencer #(
  parameter  int N  = 20,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          sr_load,
  output logic          sr_enable,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          acc_msb,
  output logic [CW-1:0] bit_idx,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;

  // A new sample may enter from IDLE, or from DONE in the same cycle the
  // result is consumed, which keeps back-to-back samples gap-free.
  assign in_ready = resetn & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign sr_load  = accept;
  assign acc_clr  = accept;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_enable = 1'b0;
    acc_en    = 1'b0;
    acc_msb   = 1'b0;
    bit_idx   = '0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        sr_enable = 1'b1;
        acc_en    = 1'b1;
        bit_idx   = cnt;
        // The last bit is the two's-complement sign bit: subtract it.
        acc_msb   = (cnt == LAST);
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = accept ? SHIFT : IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_da_bit_sequencer.sv
// Bench for da_bit_sequencer: cycle vectors built from the accept/shift/done
// timeline, checked through a scoreboard queue on two instances (N=20, N=2).
module tb_da_bit_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b1;
  logic iv_a = 1'b0, or_a = 1'b0, iv_b = 1'b0, or_b = 1'b0;

  logic       ir_a, ld_a, en_a, clr_a, acen_a, msb_a, busy_a, ov_a;
  logic [4:0] idx_a;
  logic       ir_b, ld_b, en_b, clr_b, acen_b, msb_b, busy_b, ov_b;
  logic [0:0] idx_b;

  da_bit_sequencer #(.N(20)) u_dut (
    .clk(clk), .resetn(resetn), .in_valid(iv_a), .in_ready(ir_a),
    .sr_load(ld_a), .sr_enable(en_a), .acc_clr(clr_a), .acc_en(acen_a),
    .acc_msb(msb_a), .bit_idx(idx_a), .busy(busy_a), .out_valid(ov_a),
    .out_ready(or_a)
  );

  da_bit_sequencer #(.N(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .in_valid(iv_b), .in_ready(ir_b),
    .sr_load(ld_b), .sr_enable(en_b), .acc_clr(clr_b), .acc_en(acen_b),
    .acc_msb(msb_b), .bit_idx(idx_b), .busy(busy_b), .out_valid(ov_b),
    .out_ready(or_b)
  );

  // exp layout: {in_ready, sr_load, sr_enable, acc_clr, acc_en, acc_msb, busy, out_valid, bit_idx[4:0]}
  typedef struct {
    int         tid;
    bit         sel;
    bit         rn;
    bit         iv;
    bit         ordy;
    logic [12:0] exp;
  } cyc_t;

  cyc_t        vec[$];
  logic [12:0] sb[$];
  logic [12:0] act, want;
  int          n_chk = 0;
  int          n_pass = 0;
  int          en_cnt = 0;

  function automatic string tname(int tid);
    case (tid)
      0: return "reset";
      1: return "single";
      2: return "backpressure";
      3: return "back2back";
      4: return "valid_in_shift";
      5: return "reset_mid_op";
      default: return "n2_min_width";
    endcase
  endfunction

  function automatic logic [12:0] mk(bit ir, bit ld, bit en, bit msb, bit bsy, bit ov, int idx);
    logic [4:0] i5;
    i5 = 5'(idx);
    return {ir, ld, en, ld, en, msb, bsy, ov, i5};
  endfunction

  task automatic push(int tid, bit sel, bit rn, bit iv, bit ordy, logic [12:0] e);
    cyc_t c;
    c.tid = tid; c.sel = sel; c.rn = rn; c.iv = iv; c.ordy = ordy; c.exp = e;
    vec.push_back(c);
  endtask

  task automatic idle(int tid, bit sel, int n);
    for (int k = 0; k < n; k++) push(tid, sel, 1, 0, 1, mk(1, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic accept_idle(int tid, bit sel);
    push(tid, sel, 1, 1, 1, mk(1, 1, 0, 0, 0, 0, 0));
  endtask

  // nb-bit shift phase, optionally truncated to len cycles; in_valid raised from cycle iv_from
  task automatic shift(int tid, bit sel, int nb, int iv_from, int len);
    for (int k = 0; k < len; k++)
      push(tid, sel, 1, (k >= iv_from), 1, mk(0, 0, 1, (k == nb - 1), 1, 0, k));
  endtask

  task automatic stall(int tid, bit sel, int n, bit iv);
    for (int k = 0; k < n; k++) push(tid, sel, 1, iv, 0, mk(0, 0, 0, 0, 1, 1, 0));
  endtask

  task automatic release_done(int tid, bit sel, bit iv);
    push(tid, sel, 1, iv, 1, mk(1, iv, 0, 0, 1, 1, 0));
  endtask

  task automatic rst(int tid, bit sel, int n);
    for (int k = 0; k < n; k++) push(tid, sel, 0, 1, 1, mk(0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #2 resetn = 1'b0;

    rst(0, 0, 3);
    idle(0, 0, 1);

    accept_idle(1, 0); shift(1, 0, 20, 99, 20); release_done(1, 0, 0); idle(1, 0, 2);

    accept_idle(2, 0); shift(2, 0, 20, 99, 20); stall(2, 0, 7, 1);
    release_done(2, 0, 0); idle(2, 0, 1);

    accept_idle(3, 0);
    for (int s = 0; s < 3; s++) begin
      shift(3, 0, 20, 99, 20); release_done(3, 0, 1);
    end
    shift(3, 0, 20, 99, 20); release_done(3, 0, 0); idle(3, 0, 1);

    accept_idle(4, 0); shift(4, 0, 20, 2, 20); release_done(4, 0, 1);
    shift(4, 0, 20, 99, 20); release_done(4, 0, 0); idle(4, 0, 1);

    accept_idle(5, 0); shift(5, 0, 20, 99, 9); rst(5, 0, 2);
    accept_idle(5, 0); shift(5, 0, 20, 99, 20); release_done(5, 0, 0); idle(5, 0, 1);

    idle(6, 1, 1); accept_idle(6, 1); shift(6, 1, 2, 99, 2); release_done(6, 1, 1);
    shift(6, 1, 2, 99, 2); stall(6, 1, 2, 0); release_done(6, 1, 0); idle(6, 1, 1);

    for (int i = 0; i < vec.size(); i++) begin
      @(posedge clk);
      #1;
      resetn = vec[i].rn;
      if (vec[i].sel) begin
        iv_b = vec[i].iv; or_b = vec[i].ordy; iv_a = 1'b0; or_a = 1'b1;
      end else begin
        iv_a = vec[i].iv; or_a = vec[i].ordy; iv_b = 1'b0; or_b = 1'b1;
      end
      sb.push_back(vec[i].exp);
      @(negedge clk);
      if (vec[i].sel)
        act = {ir_b, ld_b, en_b, clr_b, acen_b, msb_b, busy_b, ov_b, 4'b0000, idx_b};
      else
        act = {ir_a, ld_a, en_a, clr_a, acen_a, msb_a, busy_a, ov_a, idx_a};
      want = sb.pop_front();
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s vec%0d: got %b required %b", tname(vec[i].tid), i, act, want);
      if (vec[i].tid == 3 && act[10] === 1'b1) en_cnt++;
    end

    n_chk++;
    if (en_cnt == 80) n_pass++;
    else $display("FAIL back2back_enable_count: got %0d required 80", en_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
